// File: rtl/arch_state_regs_pkg.sv
// Shared CPU definitions used by the write-back architectural state block.
// Constants for the zero word, GPR count, the hardwired-zero register and enables.
package arch_state_regs_pkg;

  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
  localparam int unsigned REG_NUM      = 32'd32;
  localparam logic [4:0]  NOP_REG_ADDR = 5'd0;
  localparam logic        WriteEnable  = 1'b1;
  localparam logic        WriteDisable = 1'b0;
  localparam logic        ReadEnable   = 1'b1;
  localparam logic        ReadDisable  = 1'b0;

endpackage

// File: rtl/arch_state_regs_if.sv
// Write-back update and ID/EX/MEM read bus of the architectural state block.
// The master modport is the pipeline side; the slave modport is the state holder.
interface arch_state_regs_if #(
  parameter int DW = 32,
  parameter int AW = 5
);

  logic          wb_we;
  logic [AW-1:0] wb_waddr;
  logic [DW-1:0] wb_wdata;
  logic          wb_whilo;
  logic [DW-1:0] wb_hi;
  logic [DW-1:0] wb_lo;
  logic          LLbit_we_i;
  logic          LLbit_value_i;
  logic          flush;
  logic          re1;
  logic [AW-1:0] raddr1;
  logic [DW-1:0] rdata1;
  logic          re2;
  logic [AW-1:0] raddr2;
  logic [DW-1:0] rdata2;
  logic [DW-1:0] hi_o;
  logic [DW-1:0] lo_o;
  logic          LLbit_o;

  modport master (
    output wb_we, wb_waddr, wb_wdata, wb_whilo, wb_hi, wb_lo,
    output LLbit_we_i, LLbit_value_i, flush,
    output re1, raddr1, re2, raddr2,
    input  rdata1, rdata2, hi_o, lo_o, LLbit_o
  );

  modport slave (
    input  wb_we, wb_waddr, wb_wdata, wb_whilo, wb_hi, wb_lo,
    input  LLbit_we_i, LLbit_value_i, flush,
    input  re1, raddr1, re2, raddr2,
    output rdata1, rdata2, hi_o, lo_o, LLbit_o
  );

endinterface

// File: rtl/arch_state_regs_gpr_file.sv
// 32-entry general purpose register file with two write-through read ports.
// Register 0 is hardwired to zero on both the write and the read side.
module arch_state_regs_gpr_file
  import arch_state_regs_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re1_i,
  input  logic [AW-1:0] raddr1_i,
  output logic [DW-1:0] rdata1_o,
  input  logic          re2_i,
  input  logic [AW-1:0] raddr2_i,
  output logic [DW-1:0] rdata2_o
);

  logic [DW-1:0] gpr_q [REG_NUM];

  // Storage update; writes aimed at register 0 are discarded
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < REG_NUM; i++) begin
        gpr_q[i] <= ZERO_WORD;
      end
    end else if ((we_i == WriteEnable) && (waddr_i != NOP_REG_ADDR)) begin
      gpr_q[waddr_i] <= wdata_i;
    end
  end

  // Read port 1 with same-cycle bypass of the write-back value
  always_comb begin
    rdata1_o = ZERO_WORD;
    if (!reset_n) begin
      rdata1_o = ZERO_WORD;
    end else if (raddr1_i == NOP_REG_ADDR) begin
      rdata1_o = ZERO_WORD;
    end else if ((we_i == WriteEnable) && (raddr1_i == waddr_i) && (re1_i == ReadEnable)) begin
      rdata1_o = wdata_i;
    end else if (re1_i == ReadEnable) begin
      rdata1_o = gpr_q[raddr1_i];
    end else begin
      rdata1_o = ZERO_WORD;
    end
  end

  // Read port 2 with same-cycle bypass of the write-back value
  always_comb begin
    rdata2_o = ZERO_WORD;
    if (!reset_n) begin
      rdata2_o = ZERO_WORD;
    end else if (raddr2_i == NOP_REG_ADDR) begin
      rdata2_o = ZERO_WORD;
    end else if ((we_i == WriteEnable) && (raddr2_i == waddr_i) && (re2_i == ReadEnable)) begin
      rdata2_o = wdata_i;
    end else if (re2_i == ReadEnable) begin
      rdata2_o = gpr_q[raddr2_i];
    end else begin
      rdata2_o = ZERO_WORD;
    end
  end

endmodule

// File: rtl/arch_state_regs.sv
// Architectural state written by write-back: GPR file, HI/LO pair and LLbit.
// All reads see the value being written in the same cycle.
module arch_state_regs
  import arch_state_regs_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input logic               clk,
  input logic               reset_n,
  arch_state_regs_if.slave  bus
);

  logic [DW-1:0] hi_q;
  logic [DW-1:0] hi_d;
  logic [DW-1:0] lo_q;
  logic [DW-1:0] lo_d;
  logic          llbit_q;
  logic          llbit_d;

  arch_state_regs_gpr_file #(
    .DW (DW),
    .AW (AW)
  ) u_gpr_file (
    .clk      (clk),
    .reset_n  (reset_n),
    .we_i     (bus.wb_we),
    .waddr_i  (bus.wb_waddr),
    .wdata_i  (bus.wb_wdata),
    .re1_i    (bus.re1),
    .raddr1_i (bus.raddr1),
    .rdata1_o (bus.rdata1),
    .re2_i    (bus.re2),
    .raddr2_i (bus.raddr2),
    .rdata2_o (bus.rdata2)
  );

  // Next HI/LO and LLbit; these double as the bypassed read values
  always_comb begin
    hi_d    = hi_q;
    lo_d    = lo_q;
    llbit_d = llbit_q;
    if (bus.wb_whilo == WriteEnable) begin
      hi_d = bus.wb_hi;
      lo_d = bus.wb_lo;
    end else begin
      hi_d = hi_q;
      lo_d = lo_q;
    end
    if (bus.flush) begin
      llbit_d = 1'b0;
    end else if (bus.LLbit_we_i == WriteEnable) begin
      llbit_d = bus.LLbit_value_i;
    end else begin
      llbit_d = llbit_q;
    end
  end

  // HI/LO and LLbit storage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_q    <= ZERO_WORD;
      lo_q    <= ZERO_WORD;
      llbit_q <= 1'b0;
    end else begin
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      llbit_q <= llbit_d;
    end
  end

  // Outputs are forced to zero while reset is held, bypass included
  always_comb begin
    bus.hi_o    = ZERO_WORD;
    bus.lo_o    = ZERO_WORD;
    bus.LLbit_o = 1'b0;
    if (!reset_n) begin
      bus.hi_o    = ZERO_WORD;
      bus.lo_o    = ZERO_WORD;
      bus.LLbit_o = 1'b0;
    end else begin
      bus.hi_o    = hi_d;
      bus.lo_o    = lo_d;
      bus.LLbit_o = llbit_d;
    end
  end

endmodule

// File: tb/tb_arch_state_regs.sv
// Directed bench for arch_state_regs: reset, GPR write/bypass, register 0,
// HI/LO pairing and LLbit flush priority, checked against hand-computed values.
module tb_arch_state_regs;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  arch_state_regs_if #(.DW(32), .AW(5)) bus ();

  arch_state_regs #(.DW(32), .AW(5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    bus.wb_we = 1'b1;  bus.wb_waddr = 5'd5;  bus.wb_wdata = 32'hCAFE_F00D;
    bus.wb_whilo = 1'b1; bus.wb_hi = 32'hAAAA_0000; bus.wb_lo = 32'h0000_BBBB;
    bus.LLbit_we_i = 1'b1; bus.LLbit_value_i = 1'b1; bus.flush = 1'b0;
    bus.re1 = 1'b1; bus.raddr1 = 5'd5;
    bus.re2 = 1'b1; bus.raddr2 = 5'd31;

    // Reset held 3 cycles; bypass candidates present but outputs must stay 0
    repeat (3) tick();
    chk("rst_rdata1", bus.rdata1, 32'h0);
    chk("rst_rdata2", bus.rdata2, 32'h0);
    chk("rst_hi", bus.hi_o, 32'h0);
    chk("rst_lo", bus.lo_o, 32'h0);
    chk("rst_llbit", {31'd0, bus.LLbit_o}, 32'h0);

    bus.wb_we = 1'b0; bus.wb_whilo = 1'b0; bus.LLbit_we_i = 1'b0;
    reset_n = 1'b1;
    #1;
    chk("post_rst_r5", bus.rdata1, 32'h0);
    chk("post_rst_hi", bus.hi_o, 32'h0);

    // Write r3, bypass the same cycle, then read from storage
    bus.wb_we = 1'b1; bus.wb_waddr = 5'd3; bus.wb_wdata = 32'hDEAD_BEEF; bus.raddr1 = 5'd3;
    #1;
    chk("r3_bypass", bus.rdata1, 32'hDEAD_BEEF);
    tick();
    bus.wb_we = 1'b0;
    #1;
    chk("r3_stored", bus.rdata1, 32'hDEAD_BEEF);
    bus.re1 = 1'b0;
    #1;
    chk("r3_re1_off", bus.rdata1, 32'h0);
    bus.re1 = 1'b1;

    // Register 0 ignores writes, both same cycle and next cycle
    bus.wb_we = 1'b1; bus.wb_waddr = 5'd0; bus.wb_wdata = 32'h1234_5678;
    bus.raddr1 = 5'd0; bus.raddr2 = 5'd0;
    #1;
    chk("r0_same1", bus.rdata1, 32'h0);
    chk("r0_same2", bus.rdata2, 32'h0);
    tick();
    bus.wb_we = 1'b0;
    #1;
    chk("r0_next", bus.rdata1, 32'h0);

    // Preload r7, then overwrite with both ports bypassing
    bus.wb_we = 1'b1; bus.wb_waddr = 5'd7; bus.wb_wdata = 32'h1111_1111;
    tick();
    bus.wb_we = 1'b0; bus.raddr1 = 5'd7; bus.raddr2 = 5'd7;
    #1;
    chk("r7_pre1", bus.rdata1, 32'h1111_1111);
    chk("r7_pre2", bus.rdata2, 32'h1111_1111);
    bus.wb_we = 1'b1; bus.wb_wdata = 32'h2222_2222;
    #1;
    chk("r7_byp1", bus.rdata1, 32'h2222_2222);
    chk("r7_byp2", bus.rdata2, 32'h2222_2222);
    tick();
    bus.wb_we = 1'b0;
    #1;
    chk("r7_held1", bus.rdata1, 32'h2222_2222);
    chk("r7_held2", bus.rdata2, 32'h2222_2222);

    // A write elsewhere must not leak onto an unrelated read address
    bus.wb_we = 1'b1; bus.wb_waddr = 5'd9; bus.wb_wdata = 32'h9999_9999; bus.raddr2 = 5'd3;
    #1;
    chk("r7_no_alias", bus.rdata1, 32'h2222_2222);
    chk("r3_no_alias", bus.rdata2, 32'hDEAD_BEEF);
    tick();
    bus.wb_we = 1'b0; bus.raddr1 = 5'd9; bus.wb_wdata = 32'h0BAD_0BAD;
    #1;
    chk("r9_stored", bus.rdata1, 32'h9999_9999);
    tick();
    chk("r9_data_only", bus.rdata1, 32'h9999_9999);

    // HI/LO written as a pair, visible same cycle, held afterwards
    bus.wb_whilo = 1'b1; bus.wb_hi = 32'hAAAA_0000; bus.wb_lo = 32'h0000_BBBB;
    #1;
    chk("hi_byp", bus.hi_o, 32'hAAAA_0000);
    chk("lo_byp", bus.lo_o, 32'h0000_BBBB);
    tick();
    bus.wb_whilo = 1'b0; bus.wb_hi = 32'h5555_5555; bus.wb_lo = 32'h6666_6666;
    #1;
    chk("hi_held", bus.hi_o, 32'hAAAA_0000);
    chk("lo_held", bus.lo_o, 32'h0000_BBBB);
    tick();
    chk("hi_held2", bus.hi_o, 32'hAAAA_0000);
    chk("lo_held2", bus.lo_o, 32'h0000_BBBB);

    // LLbit: set, then flush wins over a simultaneous set
    bus.LLbit_we_i = 1'b1; bus.LLbit_value_i = 1'b1;
    #1;
    chk("ll_byp_set", {31'd0, bus.LLbit_o}, 32'h1);
    tick();
    bus.LLbit_we_i = 1'b0;
    #1;
    chk("ll_stored1", {31'd0, bus.LLbit_o}, 32'h1);
    bus.flush = 1'b1; bus.LLbit_we_i = 1'b1; bus.LLbit_value_i = 1'b1;
    #1;
    chk("ll_flush", {31'd0, bus.LLbit_o}, 32'h0);
    tick();
    bus.flush = 1'b0; bus.LLbit_we_i = 1'b0;
    #1;
    chk("ll_flushed", {31'd0, bus.LLbit_o}, 32'h0);
    bus.LLbit_we_i = 1'b1; bus.LLbit_value_i = 1'b1;
    #1;
    chk("ll_reset", {31'd0, bus.LLbit_o}, 32'h1);
    tick();
    bus.LLbit_value_i = 1'b0;
    #1;
    chk("ll_clear_byp", {31'd0, bus.LLbit_o}, 32'h0);
    tick();
    bus.LLbit_we_i = 1'b0;
    #1;
    chk("ll_cleared", {31'd0, bus.LLbit_o}, 32'h0);

    // Asynchronous reset mid-run clears storage without a clock edge
    bus.raddr1 = 5'd7; bus.raddr2 = 5'd3;
    bus.LLbit_we_i = 1'b1; bus.LLbit_value_i = 1'b1;
    tick();
    bus.LLbit_we_i = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("arst_rdata1", bus.rdata1, 32'h0);
    chk("arst_llbit", {31'd0, bus.LLbit_o}, 32'h0);
    reset_n = 1'b1;
    #1;
    chk("arst_r7", bus.rdata1, 32'h0);
    chk("arst_r3", bus.rdata2, 32'h0);
    chk("arst_hi", bus.hi_o, 32'h0);
    chk("arst_lo", bus.lo_o, 32'h0);
    chk("arst_ll", {31'd0, bus.LLbit_o}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
